// File: rtl/reset_sequencer_pkg.sv
// Purpose: shared state encodings and sizing helper for the reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rst_seq_pkg;

    // Sequencer FSM states (fixed encodings so the state is easy to decode in a waveform)
    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_STABLE    = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_WAIT_RDY  = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_TIMEOUT   = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    // One shared cycle counter serves the lock-stable, ready-wait and gap phases,
    // so it must hold the largest of the three limits.
    function automatic int cnt_width(input int stable_len, input int rdy_timeout,
                                     input int stage_gap);
        int m;
        m = (stable_len > rdy_timeout) ? stable_len : rdy_timeout;
        m = (m > stage_gap) ? m : stage_gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// Purpose: WIDTH-bit two-flop synchroniser with synchronous clear.
// Latency: 2 cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rst (sync active-high clear), d (async inputs), q (synchronised outputs).
module bit_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Purpose: releases per-subsystem resets in index order once the clock is locked and stable,
//          waiting for each stage's ready before the next; restarts on lock loss, timeout or dropout.
// Latency: lock (synchronised) to stage_rst[0] release = STABLE_LEN + 2 cycles; async inputs add 2 sync cycles.
// Backpressure: none; each stage's ready acts as the acknowledge gating the next release.
// Ports: clk, rst (sync active-high), locked, stage_rdy[STAGES] (async in);
//        stage_rst[STAGES] (active-high, registered), done, fault (sticky), retry_cnt (out).
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int STABLE_LEN  = 1000,
    parameter int STAGE_GAP   = 16,
    parameter int RDY_TIMEOUT = 65535,
    parameter int MAX_RETRIES = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               locked,
    input  logic [STAGES-1:0]                  stage_rdy,
    output logic [STAGES-1:0]                  stage_rst,
    output logic                               done,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

    localparam int CW   = cnt_width(STABLE_LEN, RDY_TIMEOUT, STAGE_GAP);
    localparam int KW   = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int RCW  = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0]  STABLE_LAST = CW'(STABLE_LEN - 1);
    localparam logic [CW-1:0]  RDY_LAST    = CW'(RDY_TIMEOUT - 1);
    localparam logic [CW-1:0]  GAP_LAST    = CW'(STAGE_GAP - 1);
    localparam logic [KW-1:0]  K_LAST      = KW'(STAGES - 1);
    localparam logic [RCW-1:0] RC_MAX      = RCW'(MAX_RETRIES);

    logic              lk;
    logic [STAGES-1:0] rdy;

    bit_sync #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lk)
    );

    bit_sync #(.WIDTH(STAGES)) u_rdy_sync (
        .clk (clk),
        .rst (rst),
        .d   (stage_rdy),
        .q   (rdy)
    );

    logic [2:0]        state_q,     state_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [KW-1:0]     k_q,         k_d;
    logic [STAGES-1:0] stage_rst_q, stage_rst_d;
    logic              done_q,      done_d;
    logic              fault_q,     fault_d;
    logic [RCW-1:0]    retry_q,     retry_d;

    logic [STAGES-1:0] prior_mask;   // stages already released and acknowledged (index < k)
    logic              dropout;      // an acknowledged stage lost its ready
    logic              restart;      // retry-counted restart request

    always_comb begin
        prior_mask = '0;
        for (int j = 0; j < STAGES; j++) begin
            prior_mask[j] = (KW'(j) < k_q);
        end
        dropout = |(prior_mask & ~rdy);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        stage_rst_d = stage_rst_q;
        fault_d     = fault_q;
        retry_d     = retry_q;
        restart     = 1'b0;

        case (state_q)
            S_WAIT_LOCK: begin
                stage_rst_d = '1;
                cnt_d       = '0;
                k_d         = '0;
                if (lk) begin
                    state_d = S_STABLE;
                end
            end
            S_STABLE: begin
                if (cnt_q == STABLE_LAST) begin
                    cnt_d   = '0;
                    k_d     = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                stage_rst_d[k_q] = 1'b0;
                cnt_d            = '0;
                state_d          = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                // ready is checked before the timeout compare so a coincident ready wins
                if (dropout) begin
                    restart = 1'b1;
                end else if (rdy[k_q]) begin
                    cnt_d   = '0;
                    state_d = (k_q == K_LAST) ? S_DONE : S_GAP;
                end else if (cnt_q == RDY_LAST) begin
                    state_d = S_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (dropout) begin
                    restart = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    k_d     = k_q + 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!(&rdy)) begin
                    restart = 1'b1;
                end
            end
            S_TIMEOUT: begin
                restart = 1'b1;
            end
            S_HALT: begin
                stage_rst_d = '1;
            end
            default: begin
                state_d = S_WAIT_LOCK;
            end
        endcase

        // Timeouts and ready dropouts share one path: re-assert everything and
        // either burn a retry or give up for good.
        if (restart) begin
            stage_rst_d = '1;
            cnt_d       = '0;
            if (retry_q == RC_MAX) begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = S_WAIT_LOCK;
            end
        end

        // Lock loss overrides everything and is not charged as a retry.
        if (!lk && (state_q != S_WAIT_LOCK) && (state_q != S_HALT)) begin
            state_d     = S_WAIT_LOCK;
            stage_rst_d = '1;
            cnt_d       = '0;
            fault_d     = fault_q;
            retry_d     = retry_q;
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            k_q         <= '0;
            stage_rst_q <= '1;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            stage_rst_q <= stage_rst_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            retry_q     <= retry_d;
        end
    end

    assign stage_rst = stage_rst_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule
